// File: rtl/wrr_resource_scheduler.sv
`timescale 1ns/1ps
// wrr_resource_scheduler
// Weighted round-robin scheduler for one exclusive resource shared by N
// requesters. A grant is held for a whole transaction and ends when the owner
// signals done, drops its request, or the hold timer expires. Each requester
// may win up to its weight consecutive arbitrations before the round-robin
// pointer moves past it. Consecutive grants are always separated by two
// cycles with the grant vector at zero: one RELEASE cycle, then the IDLE
// arbitration edge.
module wrr_resource_scheduler #(
    parameter int N        = 8,
    parameter int W        = 4,
    parameter int MAX_HOLD = 16,
    localparam int M       = $clog2(N)
) (
    input  logic             i_clk,
    input  logic             i_rstn,      // active-high asynchronous reset
    input  logic [N-1:0]     i_req,
    input  logic             i_done,
    input  logic [N*W-1:0]   i_wt,
    input  logic             i_wt_ld,
    output logic [N-1:0]     o_gnt,
    output logic [M-1:0]     o_owner,
    output logic             o_busy,
    output logic             o_timeout
);

    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t          state_reg;
    logic [M-1:0]    ptr_reg;
    logic [M-1:0]    owner_reg;
    logic [HW-1:0]   hold_reg;
    logic [N-1:0]    gnt_reg;
    logic            busy_reg;
    logic            timeout_reg;

    // Arbitration results
    logic [M-1:0]    win_idx;
    logic            win_found;
    logic [M-1:0]    scan_idx;
    logic [N-1:0]    win_onehot;
    logic [N-1:0]    credit_last;   // requester is on its final credit
    logic            win_exhausted;
    logic [M-1:0]    ptr_next;

    // Control strobes shared by the FSM and the per-requester credit logic
    logic            arb_fire;
    logic            wt_load;
    logic            release_req;
    logic            hold_expired;

    // Arbitration and weight loading are only meaningful in IDLE; elsewhere
    // the request vector and the load strobe are deliberately ignored.
    assign arb_fire     = (state_reg == IDLE) && (|i_req);
    assign wt_load      = (state_reg == IDLE) && i_wt_ld;
    assign release_req  = i_done || !i_req[owner_reg];
    assign hold_expired = (hold_reg == HW'(MAX_HOLD));

    // Rotating priority scan: first set request at ptr, ptr+1, ..., wrapping.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        scan_idx  = '0;
        for (int k = 0; k < N; k++) begin
            scan_idx = M'((int'(ptr_reg) + k) % N);
            if (!win_found && i_req[scan_idx]) begin
                win_idx   = scan_idx;
                win_found = 1'b1;
            end
        end
    end

    // Per-requester weight and credit storage.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_req
            logic [W-1:0] weight_reg;
            logic [W-1:0] credit_reg;
            logic [W-1:0] eff_weight;
            logic [W-1:0] eff_new;

            // A programmed weight of zero behaves like one (plain round-robin).
            assign eff_weight = (weight_reg == '0) ? W'(1) : weight_reg;
            assign eff_new    = (i_wt[gi*W +: W] == '0) ? W'(1) : i_wt[gi*W +: W];

            assign win_onehot[gi]  = win_found && (win_idx == M'(gi));
            assign credit_last[gi] = (credit_reg <= W'(1));

            // Weight load refreshes every credit; otherwise only the winner
            // spends a credit and reloads once it has used its last one. A
            // load on an arbitration edge overrides that edge's decrement.
            always_ff @(posedge i_clk or posedge i_rstn) begin
                if (i_rstn) begin
                    weight_reg <= W'(1);
                    credit_reg <= W'(1);
                end else if (wt_load) begin
                    weight_reg <= i_wt[gi*W +: W];
                    credit_reg <= eff_new;
                end else if (arb_fire && win_onehot[gi]) begin
                    credit_reg <= credit_last[gi] ? eff_weight : (credit_reg - W'(1));
                end
            end
        end
    endgenerate

    // The pointer stays on the winner while it still has credit, otherwise it
    // moves one past the winner with wrap from N-1 to 0.
    assign win_exhausted = |(win_onehot & credit_last);
    assign ptr_next      = !win_exhausted ? win_idx
                         : (win_idx == M'(N - 1)) ? '0
                         : (win_idx + M'(1));

    // Main scheduler FSM with registered grant, owner, busy and timeout.
    always_ff @(posedge i_clk or posedge i_rstn) begin
        if (i_rstn) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            owner_reg   <= '0;
            hold_reg    <= '0;
            gnt_reg     <= '0;
            busy_reg    <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    timeout_reg <= 1'b0;
                    if (arb_fire) begin
                        gnt_reg   <= win_onehot;
                        owner_reg <= win_idx;
                        busy_reg  <= 1'b1;
                        hold_reg  <= HW'(1);
                        ptr_reg   <= ptr_next;
                        state_reg <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_req) begin
                        // Normal release wins over a simultaneous timeout.
                        gnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                        hold_reg  <= '0;
                        state_reg <= RELEASE;
                    end else if (hold_expired) begin
                        gnt_reg     <= '0;
                        busy_reg    <= 1'b0;
                        hold_reg    <= '0;
                        timeout_reg <= 1'b1;
                        state_reg   <= RELEASE;
                    end else begin
                        hold_reg <= hold_reg + HW'(1);
                    end
                end
                RELEASE: begin
                    // Dead cycle so the grant never moves without passing 0.
                    timeout_reg <= 1'b0;
                    state_reg   <= IDLE;
                end
                default: begin
                    gnt_reg     <= '0;
                    busy_reg    <= 1'b0;
                    timeout_reg <= 1'b0;
                    hold_reg    <= '0;
                    state_reg   <= IDLE;
                end
            endcase
        end
    end

    assign o_gnt     = gnt_reg;
    assign o_owner   = owner_reg;
    assign o_busy    = busy_reg;
    assign o_timeout = timeout_reg;

endmodule

// File: tb/tb_wrr_resource_scheduler.sv
`timescale 1ns/1ps
// Testbench for wrr_resource_scheduler (N=4, W=4, MAX_HOLD=16).
// Directed vectors and sequences for the documented corner cases, then a
// randomized run compared cycle by cycle against a transaction-level model.
module tb_wrr_resource_scheduler;

    localparam int N        = 4;
    localparam int W        = 4;
    localparam int MAX_HOLD = 16;
    localparam int M        = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic             done;
    logic [N*W-1:0]   wt;
    logic             wt_ld;
    logic [N-1:0]     gnt;
    logic [M-1:0]     owner;
    logic             busy;
    logic             tmo;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wrr_resource_scheduler #(.N(N), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
        .i_clk     (clk),
        .i_rstn    (rst),
        .i_req     (req),
        .i_done    (done),
        .i_wt      (wt),
        .i_wt_ld   (wt_ld),
        .o_gnt     (gnt),
        .o_owner   (owner),
        .o_busy    (busy),
        .o_timeout (tmo)
    );

    typedef struct {
        logic [N-1:0] req;
        logic         done;
        logic [N-1:0] gnt;
        int           owner;   // checked only when busy is expected
        logic         busy;
        logic         tmo;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive inputs, clock once, settle 1 ns past the edge.
    task automatic step(input logic [N-1:0] r, input logic d, input logic ld, input logic [N*W-1:0] w);
        req = r; done = d; wt_ld = ld; wt = w;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy(input logic [N-1:0] r);
        int k;
        k = 0;
        while (!busy && k < 10) begin
            step(r, 1'b0, 1'b0, '0);
            k++;
        end
        if (!busy) check("wait_busy_timeout", 32'(busy), 32'd1);
    endtask

    // One complete transaction: wait for grant, check owner, optionally pulse
    // a weight load while busy, then finish with done.
    task automatic grant_and_done(input string name, input logic [N-1:0] r, input int exp_owner,
                                  input logic ld, input logic [N*W-1:0] w);
        logic [N-1:0] exp_gnt;
        exp_gnt = '0;
        exp_gnt[exp_owner] = 1'b1;
        wait_busy(r);
        check({name, "_gnt"}, 32'(gnt), 32'(exp_gnt));
        check({name, "_owner"}, 32'(owner), 32'(exp_owner));
        $display("txn %s: owner %0d gnt %b", name, owner, gnt);
        step(r, 1'b0, ld, w);
        step(r, 1'b1, 1'b0, '0);
        check({name, "_rel"}, 32'(gnt), 32'd0);
    endtask

    // ---------------- reference model ----------------
    int m_owner;          // -1 when nobody holds the resource
    int m_held;
    bit m_dead;           // one dead cycle pending after a release
    int m_ptr;
    int m_wt[N];
    int m_cr[N];
    bit m_tmo;

    function automatic int eff(input int w);
        return (w == 0) ? 1 : w;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_held = 0; m_dead = 0; m_ptr = 0; m_tmo = 0;
        for (int k = 0; k < N; k++) begin
            m_wt[k] = 1;
            m_cr[k] = 1;
        end
    endtask

    task automatic model_edge(input logic [N-1:0] r, input logic d, input logic ld, input logic [N*W-1:0] w);
        int win;
        bit found;
        if (m_owner >= 0) begin
            if (d || !r[m_owner]) begin
                m_owner = -1; m_dead = 1; m_tmo = 0;
            end else if (m_held == MAX_HOLD) begin
                m_owner = -1; m_dead = 1; m_tmo = 1;
            end else begin
                m_held++;
            end
        end else if (m_dead) begin
            m_dead = 0; m_tmo = 0;
        end else begin
            m_tmo = 0;
            if (r != 0) begin
                found = 0; win = 0;
                for (int k = 0; k < N; k++) begin
                    if (!found && r[(m_ptr + k) % N]) begin
                        win = (m_ptr + k) % N;
                        found = 1;
                    end
                end
                m_owner = win; m_held = 1;
                m_cr[win] = m_cr[win] - 1;
                if (m_cr[win] == 0) begin
                    m_cr[win] = eff(m_wt[win]);
                    m_ptr = (win + 1) % N;
                end else begin
                    m_ptr = win;
                end
            end
            if (ld) begin
                for (int k = 0; k < N; k++) begin
                    m_wt[k] = int'(w[k*W +: W]);
                    m_cr[k] = eff(m_wt[k]);
                end
            end
        end
    endtask

    initial begin
        int cnt;
        logic [N-1:0] rr;
        logic dd, ll;
        logic [N*W-1:0] ww;
        int exp_seq_a[8];
        int exp_seq_b[4];
        int exp_seq_c[5];
        logic [N-1:0] m_gnt;

        exp_seq_a = '{0, 0, 0, 1, 0, 0, 0, 1};
        exp_seq_b = '{0, 1, 0, 1};
        exp_seq_c = '{0, 1, 2, 3, 0};

        // {req, done} -> {gnt, owner, busy, timeout}
        vecs[0]  = '{4'b1010, 1'b0, 4'b0010, 1, 1'b1, 1'b0};
        vecs[1]  = '{4'b1010, 1'b0, 4'b0010, 1, 1'b1, 1'b0};
        vecs[2]  = '{4'b1010, 1'b0, 4'b0010, 1, 1'b1, 1'b0};
        vecs[3]  = '{4'b1010, 1'b1, 4'b0000, 0, 1'b0, 1'b0};
        vecs[4]  = '{4'b1010, 1'b0, 4'b0000, 0, 1'b0, 1'b0};
        vecs[5]  = '{4'b1010, 1'b0, 4'b1000, 3, 1'b1, 1'b0};
        vecs[6]  = '{4'b1010, 1'b0, 4'b1000, 3, 1'b1, 1'b0};
        vecs[7]  = '{4'b1010, 1'b0, 4'b1000, 3, 1'b1, 1'b0};
        vecs[8]  = '{4'b1010, 1'b1, 4'b0000, 0, 1'b0, 1'b0};
        vecs[9]  = '{4'b1010, 1'b0, 4'b0000, 0, 1'b0, 1'b0};
        vecs[10] = '{4'b1010, 1'b0, 4'b0010, 1, 1'b1, 1'b0};

        rst = 1'b1; req = '0; done = 1'b0; wt = '0; wt_ld = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tmo", 32'(tmo), 32'd0);
        rst = 1'b0;

        // Plain round-robin with done 3 cycles after each grant.
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].req, vecs[i].done, 1'b0, '0);
            $display("vec %0d: req %b done %b -> gnt %b owner %0d busy %b tmo %b",
                     i, vecs[i].req, vecs[i].done, gnt, owner, busy, tmo);
            check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
            check($sformatf("vec%0d_tmo", i), 32'(tmo), 32'(vecs[i].tmo));
            if (vecs[i].busy) check($sformatf("vec%0d_owner", i), 32'(owner), 32'(vecs[i].owner));
        end
        step(4'b0000, 1'b1, 1'b0, '0);
        step(4'b0000, 1'b0, 1'b0, '0);

        // Weight0=3, weight1=1 loaded in IDLE.
        step(4'b0000, 1'b0, 1'b1, 16'h1113);
        for (int i = 0; i < 8; i++)
            grant_and_done($sformatf("wrr3_%0d", i), 4'b0011, exp_seq_a[i], 1'b0, '0);
        step(4'b0000, 1'b0, 1'b0, '0);
        step(4'b0000, 1'b0, 1'b1, 16'h1110);
        for (int i = 0; i < 4; i++)
            grant_and_done($sformatf("wrr0_%0d", i), 4'b0011, exp_seq_b[i], 1'b0, '0);

        // Hold timeout.
        wait_busy(4'b0100);
        check("to_first_gnt", 32'(gnt), 32'b0100);
        cnt = 1;
        while (gnt == 4'b0100 && cnt < 40) begin
            step(4'b0100, 1'b0, 1'b0, '0);
            if (gnt == 4'b0100) cnt++;
        end
        $display("txn timeout: held %0d cycles, tmo %b", cnt, tmo);
        check("to_hold_cycles", 32'(cnt), 32'(MAX_HOLD));
        check("to_pulse", 32'(tmo), 32'd1);
        step(4'b0100, 1'b0, 1'b0, '0);
        check("to_pulse_end", 32'(tmo), 32'd0);
        check("to_gap_gnt", 32'(gnt), 32'd0);
        step(4'b0100, 1'b0, 1'b0, '0);
        check("to_regrant", 32'(gnt), 32'b0100);

        // Owner drops request mid-grant.
        step(4'b0100, 1'b0, 1'b0, '0);
        step(4'b0100, 1'b0, 1'b0, '0);
        step(4'b0000, 1'b0, 1'b0, '0);
        $display("txn drop: gnt %b busy %b tmo %b", gnt, busy, tmo);
        check("drop_gnt", 32'(gnt), 32'd0);
        check("drop_busy", 32'(busy), 32'd0);
        check("drop_tmo", 32'(tmo), 32'd0);
        step(4'b0000, 1'b0, 1'b0, '0);
        check("drop_tmo2", 32'(tmo), 32'd0);

        // Weight load while busy must be ignored.
        for (int i = 0; i < 4; i++)
            grant_and_done($sformatf("ldbusy_%0d", i), 4'b0011, exp_seq_b[i], (i == 0), 16'h1113);

        // Done coincides with hold==MAX_HOLD: no timeout pulse.
        wait_busy(4'b0100);
        for (int i = 0; i < MAX_HOLD - 1; i++) step(4'b0100, 1'b0, 1'b0, '0);
        check("coin_still_gnt", 32'(gnt), 32'b0100);
        step(4'b0100, 1'b1, 1'b0, '0);
        $display("txn coincide: gnt %b tmo %b", gnt, tmo);
        check("coin_gnt", 32'(gnt), 32'd0);
        check("coin_tmo", 32'(tmo), 32'd0);
        step(4'b0000, 1'b0, 1'b0, '0);
        check("coin_tmo2", 32'(tmo), 32'd0);

        // Asynchronous reset during a grant.
        wait_busy(4'b0010);
        check("ar_pre_gnt", 32'(gnt), 32'b0010);
        #2 rst = 1'b1;
        #1;
        $display("txn async reset: gnt %b busy %b", gnt, busy);
        check("ar_gnt", 32'(gnt), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_tmo", 32'(tmo), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++)
            grant_and_done($sformatf("postrst_%0d", i), 4'b1111, exp_seq_c[i], 1'b0, '0);

        // Randomized run against the reference model.
        rst = 1'b1;
        step(4'b0000, 1'b0, 1'b0, '0);
        rst = 1'b0;
        model_reset();
        rr = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(7) == 0) rr[b] = ~rr[b];
            dd = (c < 1500) ? ($urandom_range(5) == 0) : ($urandom_range(39) == 0);
            ll = ($urandom_range(15) == 0);
            ww = N*W'($urandom);
            step(rr, dd, ll, ww);
            model_edge(rr, dd, ll, ww);
            m_gnt = '0;
            if (m_owner >= 0) m_gnt[m_owner] = 1'b1;
            if (gnt !== m_gnt || c % 200 == 0)
                $display("rnd %0d: req %b done %b ld %b -> gnt %b model %b tmo %b", c, rr, dd, ll, gnt, m_gnt, tmo);
            check($sformatf("rnd%0d_gnt", c), 32'(gnt), 32'(m_gnt));
            check($sformatf("rnd%0d_busy", c), 32'(busy), 32'(m_owner >= 0));
            check($sformatf("rnd%0d_tmo", c), 32'(tmo), 32'(m_tmo));
            if (m_owner >= 0) check($sformatf("rnd%0d_owner", c), 32'(owner), 32'(m_owner));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
